mc_control_unit_hs: RTL and testbench



---
 rtl/ctrl_pkg.sv | 43 ++++
 rtl/mc_decode_rom.sv | 48 ++++
 rtl/mc_control_unit_hs.sv | 186 ++++++++++++++++++
 tb/tb_mc_control_unit_hs.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I control unit.
// Opcodes, FSM states, trap causes and the decode-row bundle.
package ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM_ACC,
    S_WRITE_BACK,
    S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    TC_NONE    = 2'b00,
    TC_ILLEGAL = 2'b01,
    TC_TIMEOUT = 2'b10,
    TC_SYSTEM  = 2'b11
  } trap_cause_e;

  typedef struct packed {
    logic [2:0] wd_src;
    logic       alu_src;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [3:0] alucode;
    logic [2:0] lcode;
  } dec_row_t;

endpackage

// File: rtl/mc_decode_rom.sv
// Combinational opcode/funct decode into a datapath control row.
// Ports: i_opcode/i_funct3/i_bit30 in; o_row, o_illegal, o_system out.
module mc_decode_rom
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_bit30,
  output dec_row_t   o_row,
  output logic       o_illegal,
  output logic       o_system
);

  logic w_shift;
  assign w_shift = (i_funct3 == 3'b001) ||
                   (i_funct3 == 3'b101);

  always_comb begin
    o_row     = '0;
    o_illegal = 1'b0;
    o_system  = 1'b0;
    unique case (i_opcode)
      OP_R: o_row = '{3'b000, 1'b0, 2'b00, 1'b1,
                      {i_bit30, i_funct3}, 3'b000};
      // only shifts use bit 30 as SRA/SRL select
      OP_I: o_row = '{3'b000, 1'b1, 2'b00, 1'b1,
                      {i_bit30 & w_shift, i_funct3},
                      3'b000};
      OP_L: o_row = '{3'b001, 1'b1, 2'b00, 1'b1,
                      ALU_ADD, i_funct3};
      OP_S: o_row = '{3'b000, 1'b1, 2'b00, 1'b0,
                      ALU_ADD, i_funct3};
      OP_B: o_row = '{3'b000, 1'b0, 2'b01, 1'b0,
                      {1'b0, i_funct3}, 3'b000};
      OP_LUI: o_row = '{3'b010, 1'b1, 2'b00, 1'b1,
                        4'b0000, 3'b000};
      OP_AUIPC: o_row = '{3'b011, 1'b1, 2'b00, 1'b1,
                          4'b0000, 3'b000};
      OP_JAL: o_row = '{3'b100, 1'b1, 2'b10, 1'b1,
                        4'b0000, 3'b000};
      OP_JALR: o_row = '{3'b100, 1'b1, 2'b11, 1'b1,
                         4'b0000, 3'b000};
      OP_SYS: o_system = 1'b1;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_unit_hs.sv
// Multicycle RV32I control FSM with imem/dmem handshakes, wait timeout,
// trap state and retired-instruction counter.
// In: clk, rst, instr_code, imem_ready, dmem_ready, trap_clr.
// Out: imem_req, ir_we, dmem_req, dataWe, regFileWe, alucode, Lcode,
//   wdSrcMuxSel, aluSrcMuxSel, pcSrcMuxSel, pcen, trap, trap_cause, instret.
module mc_control_unit_hs
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_code,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             trap_clr,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dataWe,
  output logic             regFileWe,
  output logic [3:0]       alucode,
  output logic [2:0]       Lcode,
  output logic [2:0]       wdSrcMuxSel,
  output logic             aluSrcMuxSel,
  output logic [1:0]       pcSrcMuxSel,
  output logic             pcen,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int TW = (MEM_TIMEOUT > 1) ?
                      $clog2(MEM_TIMEOUT) : 1;

  state_e           r_state, w_next;
  trap_cause_e      r_cause, w_cause;
  logic [TW-1:0]    r_wait;
  logic [CNT_W-1:0] r_instret;

  dec_row_t w_row;
  logic     w_ill, w_sys;
  logic     w_ld, w_st, w_mem;
  logic     w_waiting, w_tmo;
  logic     w_unused;

  mc_decode_rom u_rom (
    .i_opcode  (instr_code[6:0]),
    .i_funct3  (instr_code[14:12]),
    .i_bit30   (instr_code[30]),
    .o_row     (w_row),
    .o_illegal (w_ill),
    .o_system  (w_sys)
  );

  assign w_unused = ^{instr_code[31],
                      instr_code[29:15],
                      instr_code[11:7]};

  assign w_ld  = (instr_code[6:0] == OP_L);
  assign w_st  = (instr_code[6:0] == OP_S);
  assign w_mem = w_ld | w_st;

  // a handshake state with its ready low this cycle
  assign w_waiting =
    ((r_state == S_FETCH)   && !imem_ready) ||
    ((r_state == S_MEM_ACC) && !dmem_ready);

  assign w_tmo = (MEM_TIMEOUT != 0) && w_waiting &&
                 (r_wait == TW'(MEM_TIMEOUT - 1));

  always_comb begin
    w_next  = r_state;
    w_cause = TC_NONE;
    unique case (r_state)
      S_FETCH: begin
        if (imem_ready) begin
          w_next = S_DECODE;
        end else if (w_tmo) begin
          w_next  = S_TRAP;
          w_cause = TC_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (w_sys) begin
          w_next  = S_TRAP;
          w_cause = TC_SYSTEM;
        end else if (w_ill) begin
          w_next  = S_TRAP;
          w_cause = TC_ILLEGAL;
        end else begin
          w_next = S_EXECUTE;
        end
      end
      S_EXECUTE:
        w_next = w_mem ? S_MEM_ACC : S_FETCH;
      S_MEM_ACC: begin
        if (dmem_ready) begin
          w_next = w_ld ? S_WRITE_BACK : S_FETCH;
        end else if (w_tmo) begin
          w_next  = S_TRAP;
          w_cause = TC_TIMEOUT;
        end
      end
      S_WRITE_BACK: w_next = S_FETCH;
      S_TRAP: if (trap_clr) w_next = S_FETCH;
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    dmem_req     = 1'b0;
    dataWe       = 1'b0;
    regFileWe    = 1'b0;
    alucode      = '0;
    Lcode        = '0;
    wdSrcMuxSel  = '0;
    aluSrcMuxSel = 1'b0;
    pcSrcMuxSel  = '0;
    pcen         = 1'b0;
    trap         = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      S_EXECUTE: begin
        wdSrcMuxSel  = w_row.wd_src;
        aluSrcMuxSel = w_row.alu_src;
        pcSrcMuxSel  = w_row.pc_src;
        alucode      = w_row.alucode;
        Lcode        = w_row.lcode;
        regFileWe    = w_row.reg_we & ~w_mem;
        pcen         = ~w_mem;
      end
      S_MEM_ACC: begin
        dmem_req     = 1'b1;
        alucode      = w_row.alucode;
        aluSrcMuxSel = w_row.alu_src;
        Lcode        = w_row.lcode;
        dataWe       = w_st;
        pcen         = w_st & dmem_ready;
      end
      S_WRITE_BACK: begin
        wdSrcMuxSel  = w_row.wd_src;
        aluSrcMuxSel = w_row.alu_src;
        pcSrcMuxSel  = w_row.pc_src;
        alucode      = w_row.alucode;
        Lcode        = w_row.lcode;
        regFileWe    = 1'b1;
        pcen         = 1'b1;
      end
      S_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_cause   <= TC_NONE;
      r_wait    <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      // clears on any state change, so entry always starts at 0
      if (w_waiting && (w_next == r_state))
        r_wait <= r_wait + TW'(1);
      else
        r_wait <= '0;
      if ((w_next == S_TRAP) && (r_state != S_TRAP))
        r_cause <= w_cause;
      else if ((r_state == S_TRAP) && trap_clr)
        r_cause <= TC_NONE;
      if (pcen)
        r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign trap_cause = r_cause;
  assign instret    = r_instret;

endmodule

// File: tb/tb_mc_control_unit_hs.sv
// Self-checking bench for mc_control_unit_hs.
// Directed and random instructions against a per-instruction reference model.
module tb_mc_control_unit_hs;

  localparam int TMO = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   instr_code = 32'h0;
  logic          imem_ready = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          trap_clr = 1'b0;
  logic          imem_req, ir_we, dmem_req, dataWe;
  logic          regFileWe, aluSrcMuxSel, pcen, trap;
  logic [3:0]    alucode;
  logic [2:0]    Lcode, wdSrcMuxSel;
  logic [1:0]    pcSrcMuxSel, trap_cause;
  logic [CW-1:0] instret;

  int n_pass = 0;
  int n_tot  = 0;
  int exp_n  = 0;

  always #5 clk = ~clk;

  mc_control_unit_hs #(
    .MEM_TIMEOUT(TMO),
    .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .instr_code(instr_code),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .trap_clr(trap_clr), .imem_req(imem_req),
    .ir_we(ir_we), .dmem_req(dmem_req), .dataWe(dataWe),
    .regFileWe(regFileWe), .alucode(alucode), .Lcode(Lcode),
    .wdSrcMuxSel(wdSrcMuxSel), .aluSrcMuxSel(aluSrcMuxSel),
    .pcSrcMuxSel(pcSrcMuxSel), .pcen(pcen), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );

  logic [21:0] obs;
  assign obs = {imem_req, ir_we, dmem_req, dataWe, regFileWe,
                alucode, Lcode, wdSrcMuxSel, aluSrcMuxSel,
                pcSrcMuxSel, pcen, trap, trap_cause};

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    n_tot++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  function automatic logic [21:0] ev(
    input logic ireq, irwe, dreq, dwe, rwe,
    input logic [3:0] alu,
    input logic [2:0] lc, wd,
    input logic asrc,
    input logic [1:0] ps,
    input logic pc, tr,
    input logic [1:0] tc);
    return {ireq, irwe, dreq, dwe, rwe, alu, lc, wd,
            asrc, ps, pc, tr, tc};
  endfunction

  // 0 plain, 1 load, 2 store, 3 system, 4 illegal
  function automatic int kind(input logic [31:0] ins);
    case (ins[6:0])
      7'b0000011: return 1;
      7'b0100011: return 2;
      7'b1110011: return 3;
      7'b0110011, 7'b0010011, 7'b1100011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: return 0;
      default: return 4;
    endcase
  endfunction

  // {wdSrc, aluSrc, pcSrc, regWe, alucode, Lcode}
  function automatic logic [13:0] ref_row(input logic [31:0] ins);
    logic [2:0] f3;
    logic       b30;
    f3  = ins[14:12];
    b30 = ins[30];
    case (ins[6:0])
      7'b0110011: return {3'b000, 1'b0, 2'b00, 1'b1, b30, f3, 3'b000};
      7'b0010011:
        if (f3 == 3'b001 || f3 == 3'b101)
          return {3'b000, 1'b1, 2'b00, 1'b1, b30, f3, 3'b000};
        else
          return {3'b000, 1'b1, 2'b00, 1'b1, 1'b0, f3, 3'b000};
      7'b0000011: return {3'b001, 1'b1, 2'b00, 1'b1, 4'b0000, f3};
      7'b0100011: return {3'b000, 1'b1, 2'b00, 1'b0, 4'b0000, f3};
      7'b1100011: return {3'b000, 1'b0, 2'b01, 1'b0, 1'b0, f3, 3'b000};
      7'b0110111: return {3'b010, 1'b1, 2'b00, 1'b1, 7'b0};
      7'b0010111: return {3'b011, 1'b1, 2'b00, 1'b1, 7'b0};
      7'b1101111: return {3'b100, 1'b1, 2'b10, 1'b1, 7'b0};
      7'b1100111: return {3'b100, 1'b1, 2'b11, 1'b1, 7'b0};
      default:    return 14'b0;
    endcase
  endfunction

  task automatic trap_seq(input logic [1:0] c);
    @(negedge clk);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    trap_clr   = 1'b0;
    #1 chk("trap_hold", obs, ev(0,0,0,0,0,0,0,0,0,0,0,1,c));
    @(negedge clk);
    trap_clr = 1'b1;
    #1 chk("trap_clr", obs, ev(0,0,0,0,0,0,0,0,0,0,0,1,c));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst        = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    trap_clr   = 1'b0;
    @(negedge clk);
    #1 chk("rst_out", obs, ev(1,0,0,0,0,0,0,0,0,0,0,0,0));
    chk("rst_instret", instret, 0);
    exp_n = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One instruction with imem ready on fetch cycle idly and dmem
  // ready on mem cycle ddly; abort stops after the first mem cycle.
  task automatic do_instr(input logic [31:0] ins, input int idly,
                          input int ddly, input bit abort);
    logic [13:0] r;
    logic [2:0]  wd, lc;
    logic [1:0]  ps;
    logic [3:0]  alu;
    logic        asrc, we, st, rdy, ok;
    int          kd;
    r  = ref_row(ins);
    {wd, asrc, ps, we, alu, lc} = r;
    kd = kind(ins);
    st = (kd == 2);
    ok = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      instr_code = ins;
      trap_clr   = 1'b0;
      dmem_ready = 1'b0;
      rdy        = (k == idly);
      imem_ready = rdy;
      #1;
      if (k == 0) chk("instret", instret, exp_n % 16);
      chk("fetch", obs, ev(1,rdy,0,0,0,0,0,0,0,0,0,0,0));
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      trap_seq(2'b10);
      return;
    end
    @(negedge clk);
    imem_ready = 1'b0;
    #1 chk("decode", obs, 22'h0);
    if (kd == 3) begin
      trap_seq(2'b11);
      return;
    end
    if (kd == 4) begin
      trap_seq(2'b01);
      return;
    end
    @(negedge clk);
    #1;
    if (kd == 0) begin
      chk("exec", obs, ev(0,0,0,0,we,alu,lc,wd,asrc,ps,1,0,0));
      exp_n++;
      return;
    end
    chk("exec_mem", obs, ev(0,0,0,0,0,alu,lc,wd,asrc,ps,0,0,0));
    ok = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      rdy        = (k == ddly);
      dmem_ready = rdy;
      #1 chk("mem", obs,
             ev(0,0,1,st,0,4'b0,ins[14:12],3'b0,1,2'b0,st & rdy,0,0));
      if (abort) return;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      trap_seq(2'b10);
      return;
    end
    if (st) begin
      exp_n++;
      return;
    end
    @(negedge clk);
    dmem_ready = 1'b0;
    #1 chk("wb", obs,
           ev(0,0,0,0,1,4'b0,ins[14:12],3'b001,1,2'b00,1,0,0));
    exp_n++;
  endtask

  logic [6:0] ops [11];
  logic [31:0] rins;

  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
            7'b1100111, 7'b1110011, 7'b0000000};
    apply_reset();
    do_instr(32'h002081B3, 0, 0, 0);
    do_instr(32'h0000A103, 0, 3, 0);
    do_instr(32'h0020A023, 0, 2, 0);
    do_instr(32'h0000007F, 0, 0, 0);
    do_instr(32'h002081B3, 99, 0, 0);
    do_instr(32'h002081B3, 3, 0, 0);
    do_instr(32'h00000073, 1, 0, 0);
    do_instr(32'h0000A103, 0, 9, 0);
    do_instr(32'h40315293, 0, 0, 0);
    for (int i = 0; i < 80; i++) begin
      rins = $urandom();
      if ($urandom_range(0, 10) != 10)
        rins[6:0] = ops[$urandom_range(0, 9)];
      do_instr(rins, $urandom_range(0, 4),
               $urandom_range(0, 4), 0);
    end
    do_instr(32'h0020A023, 0, 5, 1);
    chk("store_we_before_rst", dataWe, 1);
    apply_reset();
    for (int i = 0; i < 17; i++)
      do_instr(32'h002081B3, 0, 0, 0);
    @(negedge clk);
    imem_ready = 1'b0;
    #1 chk("instret_final", instret, exp_n % 16);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
